// File: rtl/if_id_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction-memory port and
// the IF/ID register outputs handed to the decoder.
//   master : the fetch stage itself (drives PC, imem address and IF/ID)
//   slave  : the surrounding pipeline (hazard unit, EX redirect, imem, ID)
interface if_id_stage_if;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_pc_add_out;
  logic        IF_ID_valid;

  modport master (
    input  stall, flush, redirect_valid, redirect_target, imem_rdata,
    output imem_addr, pc, IF_ID_instr, IF_ID_pc_add_out, IF_ID_valid
  );

  modport slave (
    output stall, flush, redirect_valid, redirect_target, imem_rdata,
    input  imem_addr, pc, IF_ID_instr, IF_ID_pc_add_out, IF_ID_valid
  );
endinterface

// File: rtl/if_id_stage.sv
// if_id_stage: fetch stage plus IF/ID pipeline register.
// Owns the PC, drives the instruction-memory address and captures the
// fetched word with its PC+4 one clock later. Priority per edge:
// redirect > flush > stall > normal fetch. Reset is synchronous, active low.
// Optional feature macro: IF_ID_PERF_CNT_EN adds saturating stall/flush
// performance counters as extra output ports.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  if_id_stage_if.master bus
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  logic [31:0] pc_q,       pc_d;
  logic [31:0] instr_q,    instr_d;
  logic [31:0] pc_add_q,   pc_add_d;
  logic        valid_q,    valid_d;
  logic [31:0] pc_plus4;

  // Wraps modulo 2^32, so 32'hFFFF_FFFC steps to 32'h0.
  assign pc_plus4 = pc_q + 32'd4;

  // Next-state selection for PC and IF/ID following the control priority.
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_add_d = pc_add_q;
    valid_d  = valid_q;
    if (bus.redirect_valid) begin
      // Target is forced word-aligned so pc[1:0] stays zero.
      pc_d     = bus.redirect_target & ~32'd3;
      instr_d  = NOP_INSTR;
      pc_add_d = 32'h0;
      valid_d  = 1'b0;
    end else if (bus.flush) begin
      // A stalled flush squashes IF/ID but must not advance the PC.
      pc_d     = bus.stall ? pc_q : pc_plus4;
      instr_d  = NOP_INSTR;
      pc_add_d = 32'h0;
      valid_d  = 1'b0;
    end else if (!bus.stall) begin
      pc_d     = pc_plus4;
      instr_d  = bus.imem_rdata;
      pc_add_d = pc_plus4;
      valid_d  = 1'b1;
    end
  end

  // PC and IF/ID register update with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pc_add_q <= 32'h0;
      valid_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_add_q <= pc_add_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.pc               = pc_q;
  assign bus.imem_addr        = pc_q;
  assign bus.IF_ID_instr      = instr_q;
  assign bus.IF_ID_pc_add_out = pc_add_q;
  assign bus.IF_ID_valid      = valid_q;

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Count pure stall edges and squash edges; both saturate at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.redirect_valid || bus.flush) begin
      if (flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_d = flush_cnt_q + 32'd1;
    end else if (bus.stall) begin
      if (stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Testbench for if_id_stage: directed steps from the stage description
// followed by randomized control traffic, checked against a cycle-level
// reference model of the fetch stage kept in this file.
module tb_if_id_stage;
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic clock;
  logic reset;
  if_id_stage_if bus();

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  if_id_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory contents: fixed word at the reset vector, otherwise
  // an address-dependent pattern so each fetch is distinguishable.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h2408_0005;
    return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234} + a;
  endfunction

  always_comb bus.imem_rdata = imem_word(bus.imem_addr);

  // Reference model state
  logic [31:0] m_pc, m_instr, m_add;
  logic        m_valid;
  logic [31:0] m_scnt, m_fcnt;

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // One clock: drive controls on the falling edge, advance the model,
  // then compare every output just after the rising edge.
  task automatic step(input logic rst_n, input logic st, input logic fl,
                      input logic rv, input logic [31:0] tgt);
    @(negedge clock);
    reset               = rst_n;
    bus.stall           = st;
    bus.flush           = fl;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
    if (!rst_n) begin
      m_pc = RESET_PC; m_instr = NOP_INSTR; m_add = 32'h0; m_valid = 1'b0;
      m_scnt = 32'h0; m_fcnt = 32'h0;
    end else if (rv || fl) begin
      m_fcnt = sat_inc(m_fcnt);
      m_instr = NOP_INSTR; m_add = 32'h0; m_valid = 1'b0;
      if (rv)       m_pc = {tgt[31:2], 2'b00};
      else if (!st) m_pc = m_pc + 32'd4;
    end else if (st) begin
      m_scnt = sat_inc(m_scnt);
    end else begin
      m_instr = imem_word(m_pc);
      m_add   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
    end
    @(posedge clock);
    #1;
    chk("pc",        bus.pc,               m_pc);
    chk("imem_addr", bus.imem_addr,        m_pc);
    chk("instr",     bus.IF_ID_instr,      m_instr);
    chk("pc_add",    bus.IF_ID_pc_add_out, m_add);
    chk("valid",     {31'h0, bus.IF_ID_valid}, {31'h0, m_valid});
`ifdef IF_ID_PERF_CNT_EN
    chk("stall_cnt", perf_stall_cnt, m_scnt);
    chk("flush_cnt", perf_flush_cnt, m_fcnt);
`endif
    $display("step rst_n=%0b st=%0b fl=%0b rv=%0b tgt=%h -> pc=%h instr=%h add=%h v=%0b",
             rst_n, st, fl, rv, tgt, bus.pc, bus.IF_ID_instr,
             bus.IF_ID_pc_add_out, bus.IF_ID_valid);
  endtask

  initial begin
    logic st, fl, rv, rs;
    reset = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_target = 32'h0;
    m_pc = 32'h0; m_instr = 32'h0; m_add = 32'h0; m_valid = 1'b0;
    m_scnt = 32'h0; m_fcnt = 32'h0;

    // Reset for two clocks
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    chk("rst_pc",    bus.pc, 32'h0000_3000);
    chk("rst_valid", {31'h0, bus.IF_ID_valid}, 32'h0);

    // First fetch after reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("first_add",   bus.IF_ID_pc_add_out, 32'h0000_3004);
    chk("first_instr", bus.IF_ID_instr,      32'h2408_0005);
    chk("first_valid", {31'h0, bus.IF_ID_valid}, 32'h1);

    // Stall three clocks: IF/ID and PC held
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("stall_instr", bus.IF_ID_instr, 32'h2408_0005);
      chk("stall_pc",    bus.pc,          32'h0000_3004);
    end

    // Redirect beats a simultaneous stall; target gets word-aligned
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_3043);
    chk("redir_pc",    bus.pc,          32'h0000_3040);
    chk("redir_instr", bus.IF_ID_instr, 32'h0);
    chk("redir_valid", {31'h0, bus.IF_ID_valid}, 32'h0);

    // Flush alone at 0x3010, then flush with stall
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_3010);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("flush_pc",    bus.pc, 32'h0000_3014);
    chk("flush_valid", {31'h0, bus.IF_ID_valid}, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("flush_stall_pc", bus.pc, 32'h0000_3018);
    chk("flush_stall_v",  {31'h0, bus.IF_ID_valid}, 32'h0);

    // PC wrap-around
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    chk("wrap_setup", bus.pc, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_pc",  bus.pc,               32'h0);
    chk("wrap_add", bus.IF_ID_pc_add_out, 32'h0);

`ifdef IF_ID_PERF_CNT_EN
    // Counter scenario: 5 stalls, 2 redirects, 1 flush from a clean reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_4000);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_5000);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("perf_stall_5", perf_stall_cnt, 32'd5);
    chk("perf_flush_3", perf_flush_cnt, 32'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("perf_stall_rst", perf_stall_cnt, 32'd0);
    chk("perf_flush_rst", perf_flush_cnt, 32'd0);
`endif

    // Randomized control traffic
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 99) < 25);
      fl = ($urandom_range(0, 99) < 10);
      rv = ($urandom_range(0, 99) < 8);
      rs = ($urandom_range(0, 99) < 3);
      step(~rs, st, fl, rv, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
